// File: rtl/tick_period_meter_pkg.sv
// Shared definitions for the tick period meter: state encoding and counter limit.
package tick_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_OVF     = 2'd2
  } state_t;

  // Largest value an m-bit cycle counter can hold (2^m - 1).
  function automatic int unsigned count_max(input int unsigned m);
    return (32'd1 << m) - 32'd1;
  endfunction

endpackage

// File: rtl/tick_period_meter_if.sv
// Tick input / measurement result bundle for the tick period meter.
interface tick_period_meter_if
  import tick_period_meter_pkg::*;
#(
  parameter int M = 8
) ();
  // tick/en are level inputs sampled every clk; valid is a one-cycle strobe
  // with no back-pressure: period is qualified only while valid is high.
  logic         tick;
  logic         en;
  logic [M-1:0] period;
  logic         valid;
  logic         locked;
  logic         overflow;
  state_t       state;

  modport master (
    output tick, en,
    input  period, valid, locked, overflow, state
  );

  modport slave (
    input  tick, en,
    output period, valid, locked, overflow, state
  );
endinterface

// File: rtl/tick_period_meter_rising_edge_detect.sv
// Registers d every cycle and flags the cycle in which it goes from 0 to 1.
module rising_edge_detect (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/tick_period_meter.sv
// Measures CLK cycles between tick rising edges; reports period, lock and overflow.
module tick_period_meter
  import tick_period_meter_pkg::*;
#(
  parameter int M          = 8,
  parameter int LOCK_COUNT = 2
) (
  input logic clk,
  input logic clear,
  tick_period_meter_if.slave bus
);
  localparam logic [M-1:0] CNT_MAX  = M'(count_max(M));
  localparam logic [3:0]   LOCK_MAX = 4'(LOCK_COUNT);

  state_t       state, state_n;
  logic [M-1:0] cnt, cnt_n;
  logic [M-1:0] period, period_n;
  logic [3:0]   match, match_n, match_hit;
  logic         valid, valid_n;
  logic         locked, locked_n;
  logic         overflow, overflow_n;
  logic         rise;

  rising_edge_detect u_edge (
    .clk   (clk),
    .clear (clear),
    .d     (bus.tick),
    .rise  (rise)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      period   <= '0;
      match    <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      period   <= period_n;
      match    <= match_n;
      valid    <= valid_n;
      locked   <= locked_n;
      overflow <= overflow_n;
    end
  end

  // Saturating match count for a measurement that repeats the previous one.
  always_comb begin
    match_hit = '0;
    if (cnt == period && period != '0)
      match_hit = (match >= LOCK_MAX) ? LOCK_MAX : match + 4'd1;
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    period_n   = period;
    match_n    = match;
    valid_n    = 1'b0;
    locked_n   = locked;
    overflow_n = overflow;
    if (!bus.en) begin
      state_n  = ST_IDLE;
      locked_n = 1'b0;
      match_n  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            cnt_n   = M'(1);
            state_n = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            period_n   = cnt;
            valid_n    = 1'b1;
            overflow_n = 1'b0;
            cnt_n      = M'(1);
            match_n    = match_hit;
            locked_n   = (match_hit == LOCK_MAX);
          end else if (cnt == CNT_MAX) begin
            state_n    = ST_OVF;
            overflow_n = 1'b1;
            locked_n   = 1'b0;
            match_n    = '0;
          end else begin
            cnt_n = cnt + M'(1);
          end
        end
        ST_OVF: begin
          // The edge ending an overflowed interval only re-arms the count.
          if (rise) begin
            cnt_n   = M'(1);
            state_n = ST_MEASURE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.period   = period;
  assign bus.valid    = valid;
  assign bus.locked   = locked;
  assign bus.overflow = overflow;
  assign bus.state    = state;
endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter (M=8, LOCK_COUNT=2) with hand-computed expectations.
module tb_tick_period_meter;
  import tick_period_meter_pkg::*;

  localparam int M = 8;

  logic clk;
  logic clear;
  int   n_checks;
  int   n_errors;

  tick_period_meter_if #(.M(M)) bus ();

  tick_period_meter #(.M(M), .LOCK_COUNT(2)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive tick for one cycle; outputs are observed 1ns after the edge that sampled it.
  task automatic step(input logic t);
    bus.tick = t;
    @(posedge clk);
    #1;
  endtask

  // Next rise arrives gap cycles after the previous one; valid must stay low in between.
  task automatic pulse_gap(input int gap);
    for (int i = 0; i < gap - 1; i++) begin
      step(1'b0);
      check("quiet_valid", 32'(bus.valid), 32'd0);
    end
    step(1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear    = 1'b1;
    bus.tick = 1'b0;
    bus.en   = 1'b1;
    #2;
    check("rst_period", 32'(bus.period), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    @(posedge clk);
    #1 clear = 1'b0;

    // 1: divide-by-10
    step(1'b1);
    check("t1_arm_valid", 32'(bus.valid), 32'd0);
    check("t1_arm_state", 32'(bus.state), 32'(ST_MEASURE));
    pulse_gap(10);
    check("t1_v1_valid", 32'(bus.valid), 32'd1);
    check("t1_v1_period", 32'(bus.period), 32'd10);
    check("t1_v1_locked", 32'(bus.locked), 32'd0);
    pulse_gap(10);
    check("t1_v2_valid", 32'(bus.valid), 32'd1);
    check("t1_v2_locked", 32'(bus.locked), 32'd0);
    pulse_gap(10);
    check("t1_v3_valid", 32'(bus.valid), 32'd1);
    check("t1_v3_locked", 32'(bus.locked), 32'd1);
    pulse_gap(10);
    check("t1_v4_period", 32'(bus.period), 32'd10);
    check("t1_v4_locked", 32'(bus.locked), 32'd1);

    // 2: switch to divide-by-7
    pulse_gap(7);
    check("t2_v1_valid", 32'(bus.valid), 32'd1);
    check("t2_v1_period", 32'(bus.period), 32'd7);
    check("t2_v1_locked", 32'(bus.locked), 32'd0);
    pulse_gap(7);
    check("t2_v2_locked", 32'(bus.locked), 32'd0);
    pulse_gap(7);
    check("t2_v3_locked", 32'(bus.locked), 32'd1);

    // 3: tick stops; overflow when cnt reaches 255
    for (int i = 0; i < 254; i++) step(1'b0);
    check("t3_pre_ovf", 32'(bus.overflow), 32'd0);
    check("t3_pre_locked", 32'(bus.locked), 32'd1);
    step(1'b0);
    check("t3_ovf", 32'(bus.overflow), 32'd1);
    check("t3_ovf_locked", 32'(bus.locked), 32'd0);
    check("t3_ovf_state", 32'(bus.state), 32'(ST_OVF));
    step(1'b0);
    step(1'b1);
    check("t3_rearm_valid", 32'(bus.valid), 32'd0);
    check("t3_rearm_ovf", 32'(bus.overflow), 32'd1);
    pulse_gap(10);
    check("t3_v_valid", 32'(bus.valid), 32'd1);
    check("t3_v_period", 32'(bus.period), 32'd10);
    check("t3_v_ovf", 32'(bus.overflow), 32'd0);

    // 4: counter range boundaries
    pulse_gap(255);
    check("t4_255_valid", 32'(bus.valid), 32'd1);
    check("t4_255_period", 32'(bus.period), 32'd255);
    check("t4_255_ovf", 32'(bus.overflow), 32'd0);
    pulse_gap(256);
    check("t4_256_valid", 32'(bus.valid), 32'd0);
    check("t4_256_ovf", 32'(bus.overflow), 32'd1);
    check("t4_256_period", 32'(bus.period), 32'd255);
    pulse_gap(10);
    check("t4_rec_period", 32'(bus.period), 32'd10);
    check("t4_rec_ovf", 32'(bus.overflow), 32'd0);
    pulse_gap(10);
    pulse_gap(10);
    check("t4_relock", 32'(bus.locked), 32'd1);

    // 5: EN low mid-measurement, rise while disabled
    step(1'b0);
    step(1'b0);
    step(1'b0);
    bus.en = 1'b0;
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("t5_dis_valid", 32'(bus.valid), 32'd0);
    check("t5_dis_locked", 32'(bus.locked), 32'd0);
    check("t5_dis_period", 32'(bus.period), 32'd10);
    check("t5_dis_state", 32'(bus.state), 32'(ST_IDLE));
    bus.en = 1'b1;
    step(1'b0);
    pulse_gap(10);
    check("t5_arm_valid", 32'(bus.valid), 32'd0);
    pulse_gap(6);
    check("t5_v_valid", 32'(bus.valid), 32'd1);
    check("t5_v_period", 32'(bus.period), 32'd6);
    check("t5_v_locked", 32'(bus.locked), 32'd0);

    // minimum period: tick toggling every cycle
    pulse_gap(2);
    check("min_valid", 32'(bus.valid), 32'd1);
    check("min_period", 32'(bus.period), 32'd2);

    // 6: asynchronous clear while locked
    pulse_gap(6);
    pulse_gap(6);
    pulse_gap(6);
    check("t6_locked", 32'(bus.locked), 32'd1);
    step(1'b0);
    step(1'b0);
    #2 clear = 1'b1;
    #1;
    check("t6_clr_period", 32'(bus.period), 32'd0);
    check("t6_clr_valid", 32'(bus.valid), 32'd0);
    check("t6_clr_locked", 32'(bus.locked), 32'd0);
    check("t6_clr_ovf", 32'(bus.overflow), 32'd0);
    check("t6_clr_state", 32'(bus.state), 32'(ST_IDLE));
    #1 clear = 1'b0;
    pulse_gap(5);
    check("t6_arm_valid", 32'(bus.valid), 32'd0);
    pulse_gap(5);
    check("t6_v_valid", 32'(bus.valid), 32'd1);
    check("t6_v_period", 32'(bus.period), 32'd5);
    step(1'b0);
    check("t6_strobe_end", 32'(bus.valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
